// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port
// shared by the loader and whatever feeds it.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [15:0] mem_write_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready,
    input  mem_write_enable, mem_write_addr, mem_write_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready,
    output mem_write_enable, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a length-prefixed byte stream
// into 16-bit instructions and writes them from base_addr upward.
module imem_loader #(
  parameter int ADDR_STEP = 2,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  imem_loader_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [16:0] MaxWords = 17'(MEM_WORDS);
  localparam logic [31:0] Step     = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [31:0] wa_q, wa_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rdy;
  logic        acc;
  logic [15:0] n_w;
  logic [15:0] cnt_inc;

  assign rdy = (state_q == LEN_HI) || (state_q == LEN_LO) ||
               (state_q == DATA_HI) || (state_q == DATA_LO);
  assign acc     = rdy && bus.rx_valid;
  assign n_w     = {len_q[15:8], bus.rx_data};
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    hi_d    = hi_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    busy    = 1'b1;
    bus.mem_write_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = LEN_HI;
          addr_d  = base_addr;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LEN_HI: if (acc) begin
        len_d[15:8] = bus.rx_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d = n_w;
        if (n_w == 16'd0) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if ({1'b0, n_w} > MaxWords) begin
          state_d = FINISH;
          err_d   = 1'b1;
        end else begin
          state_d = DATA_HI;
        end
      end
      DATA_HI: if (acc) begin
        hi_d    = bus.rx_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (acc) begin
        // Latch write-port values here so they hold after the strobe.
        wa_d    = addr_q;
        wd_d    = {hi_q, bus.rx_data};
        state_d = WRITE;
      end
      WRITE: begin
        bus.mem_write_enable = 1'b1;
        addr_d = addr_q + Step;
        cnt_d  = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = DATA_HI;
        end
      end
      FINISH: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.rx_ready       = rdy;
  assign bus.mem_write_addr = wa_q;
  assign bus.mem_write_data = wd_q;
  assign done               = done_q;
  assign error              = err_q;
  assign words_written      = cnt_q;

endmodule
